// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the EX stage: 32 shift-add or restoring
// steps on operand magnitudes, then a two-cycle sign fix-up and a one-cycle done pulse.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        stall_req,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic        fix_ph_q;
  logic [2:0]  op_q;
  logic [31:0] acc_q;
  logic [31:0] lo_q;
  logic [31:0] mb_q;
  logic        prod_neg_q, quo_neg_q, rem_neg_q;
  logic [31:0] result_q;

  logic        a_sgn, b_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic        accept, is_mul;
  logic [32:0] mul_sum;
  logic [33:0] div_diff;
  logic [63:0] prod_inv;
  logic [31:0] result_sel;

  always_comb begin
    a_sgn  = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_sgn  = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg  = a_sgn & a[31];
    b_neg  = b_sgn & b[31];
    a_mag  = a_neg ? (32'd0 - a) : a;
    b_mag  = b_neg ? (32'd0 - b) : b;
    accept = (state_q == S_IDLE) && start && !flush;
  end

  // acc_q/lo_q are shared: product {hi,lo} for multiply, {remainder,dividend->quotient} for divide
  always_comb begin
    is_mul     = ~op_q[2];
    mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, mb_q} : 33'd0);
    div_diff   = {1'b0, acc_q, lo_q[31]} - {2'b00, mb_q};
    prod_inv   = 64'd0 - {acc_q, lo_q};
    result_sel = ((op_q == 3'd0) || (op_q[2:1] == 2'b10)) ? lo_q : acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_CALC;
        S_CALC:  if (cnt_q == 5'd31) state_d = S_FIX;
        S_FIX:   if (fix_ph_q) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_req = !rst && (accept || (state_q == S_CALC) || (state_q == S_FIX));
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE) && !flush;
    result    = result_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= 5'd0;
      fix_ph_q   <= 1'b0;
      op_q       <= 3'd0;
      acc_q      <= 32'd0;
      lo_q       <= 32'd0;
      mb_q       <= 32'd0;
      prod_neg_q <= 1'b0;
      quo_neg_q  <= 1'b0;
      rem_neg_q  <= 1'b0;
      result_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q       <= op;
            lo_q       <= a_mag;
            mb_q       <= b_mag;
            acc_q      <= 32'd0;
            cnt_q      <= 5'd0;
            fix_ph_q   <= 1'b0;
            prod_neg_q <= a_neg ^ b_neg;
            // a zero divisor must keep the all-ones quotient of the raw iteration
            quo_neg_q  <= (a_neg ^ b_neg) && (b != 32'd0);
            rem_neg_q  <= a_neg;
          end
        end
        S_CALC: begin
          cnt_q <= cnt_q + 5'd1;
          if (is_mul) begin
            acc_q <= mul_sum[32:1];
            lo_q  <= {mul_sum[0], lo_q[31:1]};
          end else if (div_diff[33]) begin
            acc_q <= {acc_q[30:0], lo_q[31]};
            lo_q  <= {lo_q[30:0], 1'b0};
          end else begin
            acc_q <= div_diff[31:0];
            lo_q  <= {lo_q[30:0], 1'b1};
          end
        end
        S_FIX: begin
          // the 64-bit negate gets its own cycle, the result mux the next one
          if (!flush) begin
            if (!fix_ph_q) begin
              fix_ph_q <= 1'b1;
              if (is_mul) begin
                if (prod_neg_q) {acc_q, lo_q} <= prod_inv;
              end else begin
                if (quo_neg_q) lo_q  <= 32'd0 - lo_q;
                if (rem_neg_q) acc_q <= 32'd0 - acc_q;
              end
            end else begin
              result_q <= result_sel;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M corner cases plus random ops
// checked against a plain-arithmetic reference model, with flush/reset/back-to-back.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        flush;
  logic        stall_req, busy, done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_res = 32'd0;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .stall_req(stall_req), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    int sx, sy;
    logic [31:0] r;
    sx = x;
    sy = y;
    r  = 32'd0;
    case (o)
      3'd0: begin p = {32'd0, x} * {32'd0, y}; r = p[31:0]; end
      3'd1: begin p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); r = p[63:32]; end
      3'd2: begin p = {{32{x[31]}}, x} * {32'd0, y}; r = p[63:32]; end
      3'd3: begin p = {32'd0, x} * {32'd0, y}; r = p[63:32]; end
      3'd4: if (y == 0) r = 32'hFFFFFFFF;
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'h80000000;
            else r = 32'(sx / sy);
      3'd5: r = (y == 0) ? 32'hFFFFFFFF : x / y;
      3'd6: if (y == 0) r = x;
            else if (x == 32'h80000000 && y == 32'hFFFFFFFF) r = 32'd0;
            else r = 32'(sx % sy);
      default: r = (y == 0) ? x : x % y;
    endcase
    return r;
  endfunction

  // One complete operation: accept, latency, stall/busy envelope, result, return to idle.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] expv, input string tag);
    int k;
    bit env_bad;
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    #1;
    checks++;
    if (stall_req !== 1'b1) begin
      errors++; $display("FAIL %s accept_stall got=%b want=1", tag, stall_req);
    end
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
    k = 0; env_bad = 0;
    while (done !== 1'b1 && k < 60) begin
      if (stall_req !== 1'b1 || busy !== 1'b1) env_bad = 1;
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 34) begin errors++; $display("FAIL %s latency got=%0d want=34", tag, k); end
    checks++;
    if (env_bad) begin errors++; $display("FAIL %s stall_busy_envelope got=dropped want=held", tag); end
    checks++;
    if (result !== expv) begin errors++; $display("FAIL %s result got=%h want=%h", tag, result, expv); end
    checks++;
    if (stall_req !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL %s done_cycle stall=%b busy=%b want stall=0 busy=1", tag, stall_req, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL %s after_done done=%b busy=%b want 0 0", tag, done, busy);
    end
    last_res = expv;
    $display("op=%0d a=%h b=%h result=%h expected=%h latency=%0d [%s]", o, x, y, result, expv, k, tag);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 3'd4; a = 32'd5; b = 32'd3; flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall_req !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b stall=%b result=%h want 0 0 0 00000000", busy, done, stall_req, result);
    end
    $display("reset: busy=%b done=%b stall_req=%b result=%h", busy, done, stall_req, result);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, "mul_neg");
    run_op(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min");
    run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max");
    run_op(3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_neg");
    run_op(3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_neg");
    run_op(3'd5, 32'h00001234, 32'd0,        32'hFFFFFFFF, "divu_zero");
    run_op(3'd7, 32'h00001234, 32'd0,        32'h00001234, "remu_zero");
    run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
    run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf");
    run_op(3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, "div_neg_zero");
    run_op(3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, "rem_neg_zero");
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = $urandom;
      case ($urandom_range(0, 7))
        0: y = 32'd0;
        1: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
        2: y = 32'($urandom_range(1, 16));
        3: x = 32'($urandom_range(0, 100));
        default: ;
      endcase
      run_op(o, x, y, model(o, x, y), "random");
    end
  endtask

  task automatic test_flush();
    logic [31:0] prev;
    bit saw_done;
    prev = last_res;
    @(negedge clk);
    op = 3'd4; a = $urandom; b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (stall_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle stall=%b busy=%b want 0 0", stall_req, busy);
    end
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL flush_no_done got=pulse want=none"); end
    checks++;
    if (result !== prev) begin errors++; $display("FAIL flush_result got=%h want=%h", result, prev); end
    $display("flush: result=%h held=%h done_seen=%b", result, prev, saw_done);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, "after_flush");
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    @(negedge clk);
    op = 3'd0; a = $urandom; b = $urandom; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || stall_req !== 1'b0 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b stall=%b result=%h want 0 0 0 00000000", busy, done, stall_req, result);
    end
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) saw_done = 1;
    end
    checks++;
    if (saw_done) begin errors++; $display("FAIL reset_mid_abandon got=activity want=idle"); end
    $display("reset_mid: abandoned op, result=%h", result);
    last_res = 32'd0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] x1, y1, x2, y2, e1, e2, r1, r2;
    int k, pulses, first, second;
    bit switched, extra;
    x1 = $urandom; y1 = $urandom; x2 = $urandom; y2 = 32'($urandom_range(1, 1000));
    e1 = model(3'd0, x1, y1);
    e2 = model(3'd4, x2, y2);
    r1 = 32'd0; r2 = 32'd0;
    @(negedge clk);
    op = 3'd0; a = x1; b = y1; start = 1'b1;
    k = 0; pulses = 0; first = 0; second = 0; switched = 0;
    while (k < 120 && pulses < 2) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) begin
        pulses++;
        if (pulses == 1) begin first = k; r1 = result; end
        else begin second = k; r2 = result; end
      end else if (pulses == 1 && !switched) begin
        op = 3'd4; a = x2; b = y2; switched = 1;
      end
    end
    start = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra = 1;
    end
    checks++;
    if (pulses != 2 || extra) begin
      errors++; $display("FAIL b2b_pulses got=%0d extra=%b want=2 extra=0", pulses, extra);
    end
    checks++;
    if (second - first != 36) begin
      errors++; $display("FAIL b2b_gap got=%0d want=36", second - first);
    end
    checks++;
    if (r1 !== e1) begin errors++; $display("FAIL b2b_mul got=%h want=%h", r1, e1); end
    checks++;
    if (r2 !== e2) begin errors++; $display("FAIL b2b_div got=%h want=%h", r2, e2); end
    $display("b2b: mul=%h div=%h pulses=%0d gap=%0d", r1, r2, pulses, second - first);
    last_res = e2;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have port: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  in  1  reset; asynchronous, active-high.
REQ-003 SHALL have port: start  in  1  EX-stage instruction is an M-extension op (from ID/EX control); held stable while stall_req=1.
REQ-004 SHALL have port: op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-005 SHALL have port: a  in  32  rs1 operand (post-forwarding).
REQ-006 SHALL have port: b  in  32  rs2 operand (post-forwarding).
REQ-007 SHALL have port: flush  in  1  kill in-flight op (branch/exception).
REQ-008 SHALL have port: stall_req  out  1  stall ID/EX, IF/ID and PC this cycle.
REQ-009 SHALL have port: busy  out  1  FSM not IDLE.
REQ-010 SHALL have port: done  out  1  one-cycle pulse; result valid this cycle.
REQ-011 SHALL have port: result  out  32  result; held until next accepted start.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 IDLE: start=1 and flush=0 SHALL latch op, |a|, |b| (per signedness), result signs, special-case flags; counter=0; go CALC.
REQ-014 Signedness: MULH, DIV, REM both signed; MULHSU a signed, b unsigned; others unsigned.
REQ-015 CALC SHALL perform one iteration per cycle for 32 cycles (counter 0..31), then go FIX.
REQ-016 Multiply SHALL be radix-2 shift-add on magnitudes into a 64-bit product.
REQ-017 Divide SHALL be restoring, one quotient bit per cycle, 32-bit quotient and remainder.
REQ-018 FIX SHALL apply two's-complement sign correction: product negated if sign(a) XOR sign(b); quotient likewise; remainder takes sign of a. Selected result SHALL be registered; go DONE.
REQ-019 Selection: MUL low 32 product bits; MULH/MULHSU/MULHU high 32; DIV/DIVU quotient; REM/REMU remainder.
REQ-020 DONE SHALL assert done=1 for exactly one cycle, then go IDLE unconditionally; start ignored in DONE.
REQ-021 Latency SHALL be fixed: start accepted at edge E0 -> done=1 in the cycle following edge E34 for every op, special cases included.
REQ-022 stall_req SHALL be combinational: (state==IDLE and start and not flush) or state==CALC or state==FIX; 0 in DONE so the pipeline advances once.
REQ-023 busy SHALL be 1 in CALC, FIX, DONE.
REQ-024 Divide by zero: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU remainder = a.
REQ-025 Signed overflow (a=0x80000000, b=0xFFFFFFFF): DIV 0x80000000; REM 0x00000000.
REQ-026 flush=1 in any state SHALL force IDLE next edge, suppress done, leave result unchanged; flush wins over simultaneous start.
REQ-027 Operand changes on a/b after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, counter=0, done=0, busy=0, result=0x00000000; stall_req=0 while rst=1.
REQ-029 Reset mid-operation SHALL abandon the op; no done pulse after release.

Verification
REQ-030 MUL a=7, b=0xFFFFFFFD -> stall_req high E0..E33, done after E34, result 0xFFFFFFEB.
REQ-031 MULH a=b=0x80000000 -> result 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-032 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
REQ-033 DIVU a=0x1234, b=0 -> 0xFFFFFFFF; REMU -> 0x00001234; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-034 Start DIV, flush at cycle 10 -> IDLE next edge, stall_req 0, no done, result keeps previous value; next start completes normally.
REQ-035 Back-to-back MUL then DIV with start held through DONE -> exactly two done pulses, second op accepted only at edge after DONE.
